mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-master front end for the memory management unit; sits directly upstream of it.
- Accepts instruction-fetch requests from the IF stage and load/store requests from the MEM stage, and serialises them into one MMU access at a time.
- Holds each access long enough for the SRAM to settle, captures the read data and returns a one-cycle ack to the requester.
- Drives the pipeline stall while either request is outstanding; throttles UART data writes until the transmitter is ready.

Parameters:
ACCESS_CYCLES, 2, cycles the MMU strobe is held per access; legal 1..15
UART_SEL_BIT, 29, address bit that selects the UART window
UART_STAT_BIT, 2, address bit that selects the UART status register (1) vs data register (0)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active low
if_req  in  1  instruction fetch request, held until if_ack
if_addr  in  32  fetch byte address
if_rdata  out  32  fetched word
if_ack  out  1  one-cycle fetch completion pulse
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_byte  in  1  byte-mode access
dm_addr  in  32  data byte address
dm_wdata  in  32  store data
dm_rdata  out  32  load data
dm_ack  out  1  one-cycle data completion pulse
stall  out  1  pipeline stall request
mmu_read  out  1  to MMU if_read
mmu_write  out  1  to MMU if_write
mmu_addr  out  32  to MMU addr
mmu_wdata  out  32  to MMU input_data
mmu_byte  out  1  to MMU bytemode
mmu_rdata  in  32  from MMU output_data
uart_tx_ready  in  1  UART transmitter idle (tbre & tsre)

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - state = IDLE.
  - All outputs are 0: mmu_*, if_rdata, dm_rdata, acks.
  - stall is combinational and follows the request inputs after reset.
  - An access in flight is dropped with no ack.
- States: IDLE, UART_WAIT, ACCESS, DONE; registered source flag src (0 = inst, 1 = data); down-counter cnt, 4 bits.
- IDLE:
  - dm_req=1 and it is a UART data write (dm_we=1, dm_addr[UART_SEL_BIT]=1, dm_addr[UART_STAT_BIT]=0): go to UART_WAIT, src=1.
  - Otherwise dm_req=1: go to ACCESS, src=1.
  - Otherwise if_req=1: go to ACCESS, src=0.
  - Data always wins a simultaneous request; the fetch is served next.
- Entering ACCESS, registered:
  - mmu_addr, mmu_wdata and mmu_byte are taken from the selected port; fetch uses wdata=0, byte=0.
  - mmu_read=~we; mmu_write=we (we=0 for fetch).
  - cnt = ACCESS_CYCLES-1.
- UART_WAIT:
  - MMU strobes stay low.
  - When uart_tx_ready=1 at an edge, enter ACCESS as above.
  - No timeout; the wait is unbounded.
- ACCESS:
  - Strobes and address are held stable.
  - cnt>0: decrement.
  - cnt==0: at that edge capture mmu_rdata into dm_rdata (src=1, load) or if_rdata (src=0); clear strobes; go to DONE.
  - Stores do not update dm_rdata.
- DONE: assert if_ack or dm_ack (per src) for exactly this cycle, then go to IDLE. There is one idle bubble between accesses.
- Latency:
  - Request sampled at edge N; strobes high in cycles N+1..N+ACCESS_CYCLES; ack high in cycle N+ACCESS_CYCLES+1.
  - UART writes add the UART_WAIT cycles.
- stall = (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational.
- Read data registers hold their value until the next capture for the same port.
- Address and data pass through unmodified; alignment and bank selection belong to the MMU.
- Request deasserted mid-access (protocol violation): the access still completes and the ack still pulses.
- Request inputs changing while ACCESS is active are ignored; the latched values are used.

Test Plan:
- Reset then fetch: rst_n low 2 cycles, if_req=1, if_addr=0x80000000, mmu_rdata=0x3C011234 → mmu_read high for cycles 1-2, if_rdata=0x3C011234, if_ack pulse in cycle 3; stall=1 until then.
- Simultaneous requests: if_req=1 and dm_req=1 with dm_we=0, dm_addr=0x80400010 → data access first (mmu_addr=0x80400010), dm_ack, one bubble, then fetch access and if_ack; no overlap of strobes.
- Byte store: dm_we=1, dm_byte=1, dm_addr=0x80000004, dm_wdata=0x000000AB → mmu_write=1, mmu_byte=1, mmu_wdata=0xAB for ACCESS_CYCLES cycles; dm_rdata unchanged.
- UART write throttle: dm_we=1, dm_addr=0xBFD003F8, uart_tx_ready=0 for 5 cycles then 1 → no strobe for 5 cycles, then mmu_write for 2 cycles, dm_ack; a UART status read (0xBFD003FC) does not wait.
- Reset mid-access: assert rst_n=0 during the second ACCESS cycle → next edge all strobes 0, no ack, state IDLE; a held request restarts cleanly after release.
- ACCESS_CYCLES=1 build: back-to-back fetches → strobe 1 cycle, ack every 3 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one MMU port, holding each access
// for ACCESS_CYCLES cycles and returning a one-cycle ack to the requesting stage.
module mem_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned UART_SEL_BIT  = 29,
    parameter int unsigned UART_STAT_BIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_byte,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        stall,
    output logic        mmu_read,
    output logic        mmu_write,
    output logic [31:0] mmu_addr,
    output logic [31:0] mmu_wdata,
    output logic        mmu_byte,
    input  logic [31:0] mmu_rdata,
    input  logic        uart_tx_ready
);

    typedef enum logic [1:0] {IDLE, UART_WAIT, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_t      state_reg, state_next;
    logic        src_reg;
    logic [3:0]  cnt_reg;
    logic        mmu_read_reg, mmu_write_reg, mmu_byte_reg;
    logic [31:0] mmu_addr_reg, mmu_wdata_reg;
    logic [31:0] if_rdata_reg, dm_rdata_reg;

    logic        dm_uart_write;
    logic        leave_idle;
    logic        enter_access;
    logic        sel_data;

    // Writes to the UART data register must wait for the transmitter to drain.
    assign dm_uart_write = dm_we & dm_addr[UART_SEL_BIT] & ~dm_addr[UART_STAT_BIT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        leave_idle   = 1'b0;
        enter_access = 1'b0;
        sel_data     = 1'b0;
        case (state_reg)
            IDLE: begin
                sel_data = dm_req;
                if (dm_req) begin
                    leave_idle = 1'b1;
                    if (dm_uart_write) begin
                        state_next = UART_WAIT;
                    end else begin
                        state_next   = ACCESS;
                        enter_access = 1'b1;
                    end
                end else if (if_req) begin
                    leave_idle   = 1'b1;
                    state_next   = ACCESS;
                    enter_access = 1'b1;
                end
            end
            UART_WAIT: begin
                sel_data = 1'b1;
                if (uart_tx_ready) begin
                    state_next   = ACCESS;
                    enter_access = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        if_ack = 1'b0;
        dm_ack = 1'b0;
        if (state_reg == DONE) begin
            if (src_reg) begin
                dm_ack = 1'b1;
            end else begin
                if_ack = 1'b1;
            end
        end
    end

    assign stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);

    // Access parameters are latched once on entry so the requester may not disturb them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_reg       <= 1'b0;
            cnt_reg       <= 4'd0;
            mmu_read_reg  <= 1'b0;
            mmu_write_reg <= 1'b0;
            mmu_byte_reg  <= 1'b0;
            mmu_addr_reg  <= 32'd0;
            mmu_wdata_reg <= 32'd0;
            if_rdata_reg  <= 32'd0;
            dm_rdata_reg  <= 32'd0;
        end else begin
            if (leave_idle) begin
                src_reg <= sel_data;
            end
            if (enter_access) begin
                cnt_reg <= CNT_INIT;
                if (sel_data) begin
                    mmu_addr_reg  <= dm_addr;
                    mmu_wdata_reg <= dm_wdata;
                    mmu_byte_reg  <= dm_byte;
                    mmu_read_reg  <= ~dm_we;
                    mmu_write_reg <= dm_we;
                end else begin
                    mmu_addr_reg  <= if_addr;
                    mmu_wdata_reg <= 32'd0;
                    mmu_byte_reg  <= 1'b0;
                    mmu_read_reg  <= 1'b1;
                    mmu_write_reg <= 1'b0;
                end
            end else if (state_reg == ACCESS) begin
                if (cnt_reg == 4'd0) begin
                    mmu_read_reg  <= 1'b0;
                    mmu_write_reg <= 1'b0;
                    if (src_reg) begin
                        if (!mmu_write_reg) begin
                            dm_rdata_reg <= mmu_rdata;
                        end
                    end else begin
                        if_rdata_reg <= mmu_rdata;
                    end
                end else begin
                    cnt_reg <= cnt_reg - 4'd1;
                end
            end
        end
    end

    assign mmu_read  = mmu_read_reg;
    assign mmu_write = mmu_write_reg;
    assign mmu_addr  = mmu_addr_reg;
    assign mmu_wdata = mmu_wdata_reg;
    assign mmu_byte  = mmu_byte_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers queue expected responses per port, a
// negedge monitor records MMU accesses and checks every ack against the queues.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AC = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        we;
        logic        bt;
    } exp_t;

    logic        clk, rst_n;
    logic        if_req, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_byte, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        stall, mmu_read, mmu_write, mmu_byte;
    logic [31:0] mmu_addr, mmu_wdata, mmu_rdata;
    logic        uart_tx_ready;

    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   lat_i, lat_d;
    logic ready_auto = 1'b0;
    logic [31:0] dm_last_model = 32'd0;

    exp_t exp_if_q[$];
    exp_t exp_dm_q[$];

    mem_arbiter #(.ACCESS_CYCLES(AC), .UART_SEL_BIT(29), .UART_STAT_BIT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .stall(stall), .mmu_read(mmu_read), .mmu_write(mmu_write),
        .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata), .mmu_byte(mmu_byte),
        .mmu_rdata(mmu_rdata), .uart_tx_ready(uart_tx_ready)
    );

    // Memory contents seen through the MMU: a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h3C01_1234;
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F69;
    endfunction

    assign mmu_rdata = mmu_read ? mem_word(mmu_addr) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cycle);
        end
    endtask

    task automatic do_if(input logic [31:0] a, output int lat);
        exp_t e;
        logic got;
        e.addr = a; e.wdata = 32'd0; e.bt = 1'b0; e.we = 1'b0; e.rdata = mem_word(a);
        exp_if_q.push_back(e);
        if_addr = a;
        if_req  = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            lat++;
            if (if_ack) begin got = 1'b1; break; end
        end
        chk("if_ack_wait", got, 1'b1);
        @(posedge clk); #1;
        if_req  = 1'b0;
        if_addr = $urandom;
    endtask

    task automatic do_dm(input logic we, input logic bt, input logic [31:0] a,
                         input logic [31:0] wd, output int lat);
        exp_t e;
        logic got;
        e.addr = a; e.wdata = wd; e.bt = bt; e.we = we;
        e.rdata = we ? dm_last_model : mem_word(a);
        dm_last_model = e.rdata;
        exp_dm_q.push_back(e);
        dm_we = we; dm_byte = bt; dm_addr = a; dm_wdata = wd;
        dm_req = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            lat++;
            if (dm_ack) begin got = 1'b1; break; end
        end
        chk("dm_ack_wait", got, 1'b1);
        @(posedge clk); #1;
        dm_req   = 1'b0;
        dm_addr  = $urandom;
        dm_wdata = $urandom;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (ready_auto) uart_tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: records each strobe burst and matches acks against the scoreboard.
    logic        strobe_prev = 1'b0, strobe_now, prev_rst = 1'b0, prev_ready = 1'b0, ack_exp;
    logic [31:0] cur_addr, cur_wdata;
    logic        cur_rd, cur_wr, cur_bt;
    int          cur_len = 0;
    exp_t        me;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            cycle++;
            strobe_now = mmu_read | mmu_write;
            chk("stall", stall, (if_req & ~if_ack) | (dm_req & ~dm_ack));
            if (strobe_now) begin
                chk("strobe_excl", mmu_read & mmu_write, 1'b0);
                if (!strobe_prev) begin
                    cur_addr = mmu_addr; cur_wdata = mmu_wdata; cur_bt = mmu_byte;
                    cur_rd = mmu_read; cur_wr = mmu_write; cur_len = 1;
                    if (mmu_write && mmu_addr[29] && !mmu_addr[2])
                        chk("uart_ready", prev_ready, 1'b1);
                end else begin
                    cur_len++;
                    chk("strobe_stable", {mmu_addr, mmu_wdata, mmu_byte, mmu_read, mmu_write},
                        {cur_addr, cur_wdata, cur_bt, cur_rd, cur_wr});
                end
            end
            ack_exp = strobe_prev & ~strobe_now & prev_rst;
            if (ack_exp | if_ack | dm_ack) chk("ack_timing", if_ack | dm_ack, ack_exp);
            if (if_ack | dm_ack) chk("ack_excl", if_ack & dm_ack, 1'b0);
            if (if_ack) begin
                chk("if_q_nonempty", exp_if_q.size() != 0, 1'b1);
                if (exp_if_q.size() != 0) begin
                    me = exp_if_q.pop_front();
                    $display("txn if  addr=%h rdata=%h exp=%h len=%0d", cur_addr, if_rdata, me.rdata, cur_len);
                    chk("if_addr", cur_addr, me.addr);
                    chk("if_dir", {cur_rd, cur_wr}, 2'b10);
                    chk("if_wdata_byte", {cur_wdata, cur_bt}, {me.wdata, me.bt});
                    chk("if_len", cur_len, AC);
                    chk("if_rdata", if_rdata, me.rdata);
                end
            end
            if (dm_ack) begin
                chk("dm_q_nonempty", exp_dm_q.size() != 0, 1'b1);
                if (exp_dm_q.size() != 0) begin
                    me = exp_dm_q.pop_front();
                    $display("txn dm  addr=%h we=%0d byte=%0d wdata=%h rdata=%h exp=%h len=%0d",
                             cur_addr, cur_wr, cur_bt, cur_wdata, dm_rdata, me.rdata, cur_len);
                    chk("dm_addr", cur_addr, me.addr);
                    chk("dm_dir", {cur_rd, cur_wr}, {~me.we, me.we});
                    chk("dm_wdata", cur_wdata, me.wdata);
                    chk("dm_byte", cur_bt, me.bt);
                    chk("dm_len", cur_len, AC);
                    chk("dm_rdata", dm_rdata, me.rdata);
                end
            end
            strobe_prev = strobe_now;
            prev_rst    = rst_n;
            prev_ready  = uart_tx_ready;
        end
    end

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
        uart_tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", {mmu_read, mmu_write, mmu_byte}, 3'b000);
        chk("rst_mmu_addr", mmu_addr, 32'd0);
        chk("rst_mmu_wdata", mmu_wdata, 32'd0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
        chk("rst_acks", {if_ack, dm_ack}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fetch after reset
        do_if(32'h8000_0000, lat_i);
        chk("if_latency", lat_i, AC + 2);

        // Simultaneous requests: data first, then fetch after one bubble
        fork
            do_dm(1'b0, 1'b0, 32'h8040_0010, 32'h0, lat_d);
            do_if(32'h8000_0100, lat_i);
        join
        chk("sim_dm_latency", lat_d, AC + 2);
        chk("sim_if_latency", lat_i, 2 * AC + 4);

        // Byte store leaves dm_rdata unchanged
        do_dm(1'b1, 1'b1, 32'h8000_0004, 32'h0000_00AB, lat_d);
        chk("store_latency", lat_d, AC + 2);

        // UART data write throttled until transmitter ready
        uart_tx_ready = 1'b0;
        fork
            do_dm(1'b1, 1'b0, 32'hBFD0_03F8, 32'h0000_0041, lat_d);
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("uart_no_strobe", mmu_read | mmu_write, 1'b0);
                    if (i == 4) begin
                        @(posedge clk); #1;
                        uart_tx_ready = 1'b1;
                    end
                end
            end
        join
        chk("uart_latency", lat_d, AC + 7);
        uart_tx_ready = 1'b0;
        do_dm(1'b0, 1'b0, 32'hBFD0_03FC, 32'h0, lat_d);
        chk("uart_stat_latency", lat_d, AC + 2);

        // Request inputs scrambled mid-access must not disturb the latched access
        fork
            do_dm(1'b0, 1'b1, 32'h8040_0030, 32'h1111_2222, lat_d);
            begin
                @(negedge clk); @(negedge clk);
                @(posedge clk); #1;
                dm_addr = 32'h8040_0FF0; dm_we = 1'b1; dm_byte = 1'b0; dm_wdata = 32'h3333_4444;
            end
        join
        chk("scramble_latency", lat_d, AC + 2);

        // Reset during the second access cycle drops the access; held request restarts
        fork
            do_dm(1'b0, 1'b0, 32'h8040_0020, 32'h0, lat_d);
            begin
                @(posedge clk); @(posedge clk); #1;
                rst_n = 1'b0;
                @(negedge clk); @(negedge clk);
                chk("midrst_strobes", {mmu_read, mmu_write}, 2'b00);
                chk("midrst_acks", {if_ack, dm_ack}, 2'b00);
                chk("midrst_rdata", {if_rdata, dm_rdata}, 64'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(negedge clk);
                chk("midrst_idle", {mmu_read, mmu_write, dm_ack}, 3'b000);
            end
        join

        // Randomised traffic on both ports
        ready_auto = 1'b1;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    do_if(32'h8000_0000 | ($urandom & 32'h003F_FFFC), lat_i);
                end
            end
            begin
                int r;
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                    r = $urandom_range(0, 99);
                    if (r < 15)
                        do_dm(1'b1, 1'b1, 32'hBFD0_03F8, $urandom & 32'hFF, lat_d);
                    else if (r < 25)
                        do_dm(1'b0, 1'b0, 32'hBFD0_03FC, 32'h0, lat_d);
                    else if (r < 55)
                        do_dm(1'b1, 1'($urandom_range(0, 1)),
                              32'h8040_0000 | ($urandom & 32'h000F_FFFC), $urandom, lat_d);
                    else
                        do_dm(1'b0, 1'($urandom_range(0, 1)),
                              32'h8040_0000 | ($urandom & 32'h000F_FFFC), 32'h0, lat_d);
                end
            end
        join

        repeat (10) @(posedge clk);
        chk("if_q_drained", exp_if_q.size(), 0);
        chk("dm_q_drained", exp_dm_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
